// File: rtl/uart_pkg.sv
// Shared definitions for the soft-core UART bridge transmit path:
// FSM state encoding, divisor width and a divisor helper.
package uart_pkg;

    localparam int UART_DIV_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Clock cycles per bit for a given clock frequency and line rate.
    function automatic logic [UART_DIV_W-1:0] uart_divisor(input longint clk_hz, input longint baud);
        return UART_DIV_W'(clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with show-ahead output (dout is the head entry),
// so the transmitter can pop straight into its shift register.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign dout    = mem[rd_ptr_reg[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update; wrap-around is natural overflow of the low bits.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1/8N2 UART transmitter, LSB first, back-to-back frames.
// Optional parity bit when UART_TX_PARITY_EN is defined.
// All line-side outputs are registered from the FSM state, so txd, tx_busy
// and tx_done trail the state register by one cycle, uniformly.
module uart_tx
    import uart_pkg::*;
#(
    parameter int                    CLK_HZ       = 200_000_000,
    parameter int                    BAUD         = 9600,
    parameter logic [UART_DIV_W-1:0] BAUD_DIVISOR = uart_divisor(CLK_HZ, BAUD),
    parameter int                    STOP_BITS    = 1,
    parameter int                    FIFO_DEPTH   = 4,
    parameter int                    PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          txd
);

    localparam logic [UART_DIV_W-1:0] DIV_LAST = BAUD_DIVISOR - UART_DIV_W'(1);

    if (BAUD_DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx: BAUD_DIVISOR must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_t        state_reg;
    logic [UART_DIV_W-1:0] timer_reg;
    logic [2:0]            bit_cnt_reg;
    logic [1:0]            stop_cnt_reg;
    logic [7:0]            shift_reg;
    logic                  txd_reg;
    logic                  busy_reg;
    logic                  done_reg;
`ifdef UART_TX_PARITY_EN
    logic                  parity_reg;
`endif

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       bit_end;
    logic       last_stop;
    logic       frame_end;
    logic       line_next;

    assign tx_ready = !fifo_full && nrst;
    assign tx_busy  = busy_reg;
    assign tx_done  = done_reg;
    assign txd      = txd_reg;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (tx_valid && tx_ready),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Bit-end, frame-end and pop decisions; a pop happens from IDLE or at the
    // very end of the final stop bit so consecutive frames touch.
    always_comb begin
        bit_end   = (timer_reg == '0);
        last_stop = (STOP_BITS == 1) || (stop_cnt_reg == 2'd1);
        frame_end = (state_reg == STOP) && bit_end && last_stop;
        fifo_pop  = !fifo_empty && ((state_reg == IDLE) || frame_end);
    end

    // Line level implied by the current state; registered into txd.
    always_comb begin
        line_next = 1'b1;
        case (state_reg)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_next = parity_reg;
`endif
            default: line_next = 1'b1;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte being popped, captured alongside the shift register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            parity_reg <= 1'b0;
        end else if (fifo_pop) begin
            parity_reg <= (^fifo_dout) ^ PARITY_ODD[0];
        end
    end
`endif

    // Frame sequencer with registered line outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            txd_reg  <= line_next;
            busy_reg <= (state_reg != IDLE);
            done_reg <= frame_end;
            case (state_reg)
                IDLE: begin
                    if (fifo_pop) begin
                        shift_reg <= fifo_dout;
                        timer_reg <= DIV_LAST;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer_reg   <= DIV_LAST;
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                    end else begin
                        timer_reg <= timer_reg - UART_DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_reg <= DIV_LAST;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            stop_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                            state_reg    <= PARITY;
`else
                            state_reg    <= STOP;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        timer_reg <= timer_reg - UART_DIV_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        timer_reg <= DIV_LAST;
                        state_reg <= STOP;
                    end else begin
                        timer_reg <= timer_reg - UART_DIV_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            if (fifo_pop) begin
                                shift_reg <= fifo_dout;
                                timer_reg <= DIV_LAST;
                                state_reg <= START;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 2'd1;
                            timer_reg    <= DIV_LAST;
                        end
                    end else begin
                        timer_reg <= timer_reg - UART_DIV_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
